// File: rtl/bounce_draw.sv
// Animated single-rectangle renderer: a sprite over a flat background that steps once per frame
// and bounces off the active-area edges. Optional macro BOUNCE_DRAW_PALETTE_EN cycles its colour on each bounce.
module bounce_draw #(
    parameter int CORDW   = 10,
    parameter int CHW     = 4,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int RECT_W  = 32,
    parameter int RECT_H  = 24,
    parameter int SPEED_X = 2,
    parameter int SPEED_Y = 1,
    parameter int START_X = 300,
    parameter int START_Y = 200,
    parameter logic [3*CHW-1:0] RECT_COLOUR = 12'h63F,
    parameter logic [3*CHW-1:0] BG_COLOUR   = 12'h142
) (
    input  logic             pix_clk,
    input  logic             rst_pix,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    input  logic             frame,
    input  logic             pause,
    output logic             out_de,
    output logic [CHW-1:0]   out_r,
    output logic [CHW-1:0]   out_g,
    output logic [CHW-1:0]   out_b,
    output logic [CORDW-1:0] rect_x,
    output logic [CORDW-1:0] rect_y,
    output logic             hit
);

    localparam int COLW = 3 * CHW;
    localparam logic [CORDW:0] X_LIM = (CORDW+1)'(H_RES - RECT_W);
    localparam logic [CORDW:0] Y_LIM = (CORDW+1)'(V_RES - RECT_H);
    localparam logic [CORDW:0] SPD_X = (CORDW+1)'(SPEED_X);
    localparam logic [CORDW:0] SPD_Y = (CORDW+1)'(SPEED_Y);
    localparam logic [CORDW:0] W_EXT = (CORDW+1)'(RECT_W);
    localparam logic [CORDW:0] H_EXT = (CORDW+1)'(RECT_H);

    typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y} state_t;

    state_t           state_q, state_d;
    logic [CORDW-1:0] rect_x_q, rect_x_d, rect_y_q, rect_y_d;
    logic             mov_left_q, mov_left_d, mov_up_q, mov_up_d;
    logic             bounce_q, bounce_d, hit_q, hit_d;
    logic             inside1_q, inside1_d, de1_q;
    logic             out_de_q;
    logic [COLW-1:0]  colour_q, colour_d;
    logic [COLW-1:0]  rect_col;
    logic [CORDW:0]   x_ext, y_ext;

    assign x_ext = {1'b0, rect_x_q};
    assign y_ext = {1'b0, rect_y_q};

    always_comb begin
        state_d    = state_q;
        rect_x_d   = rect_x_q;
        rect_y_d   = rect_y_q;
        mov_left_d = mov_left_q;
        mov_up_d   = mov_up_q;
        bounce_d   = bounce_q;
        hit_d      = 1'b0;
        case (state_q)
            IDLE: begin
                bounce_d = 1'b0;
                if (frame && !pause) state_d = UPD_X;
            end
            UPD_X: begin
                state_d = UPD_Y;
                if (!mov_left_q) begin
                    if (x_ext + SPD_X >= X_LIM) begin
                        rect_x_d   = X_LIM[CORDW-1:0];
                        mov_left_d = 1'b1;
                        bounce_d   = 1'b1;
                    end else begin
                        rect_x_d = rect_x_q + SPD_X[CORDW-1:0];
                    end
                end else if (x_ext <= SPD_X) begin
                    rect_x_d   = '0;
                    mov_left_d = 1'b0;
                    bounce_d   = 1'b1;
                end else begin
                    rect_x_d = rect_x_q - SPD_X[CORDW-1:0];
                end
            end
            UPD_Y: begin
                state_d = IDLE;
                hit_d   = bounce_q;
                if (!mov_up_q) begin
                    if (y_ext + SPD_Y >= Y_LIM) begin
                        rect_y_d = Y_LIM[CORDW-1:0];
                        mov_up_d = 1'b1;
                        hit_d    = 1'b1;
                    end else begin
                        rect_y_d = rect_y_q + SPD_Y[CORDW-1:0];
                    end
                end else if (y_ext <= SPD_Y) begin
                    rect_y_d = '0;
                    mov_up_d = 1'b0;
                    hit_d    = 1'b1;
                end else begin
                    rect_y_d = rect_y_q - SPD_Y[CORDW-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inside1_d = ({1'b0, sx} >= x_ext) && ({1'b0, sx} < x_ext + W_EXT) &&
                    ({1'b0, sy} >= y_ext) && ({1'b0, sy} < y_ext + H_EXT);
        colour_d  = '0;
        if (de1_q) colour_d = inside1_q ? rect_col : BG_COLOUR;
    end

    // NOTE: every register here uses <= so all flops sample the same pre-edge values.
    always_ff @(posedge pix_clk) begin
        if (rst_pix) begin
            state_q    <= IDLE;
            rect_x_q   <= CORDW'(START_X);
            rect_y_q   <= CORDW'(START_Y);
            mov_left_q <= 1'b0;
            mov_up_q   <= 1'b0;
            bounce_q   <= 1'b0;
            hit_q      <= 1'b0;
            inside1_q  <= 1'b0;
            de1_q      <= 1'b0;
            out_de_q   <= 1'b0;
            colour_q   <= '0;
        end else begin
            state_q    <= state_d;
            rect_x_q   <= rect_x_d;
            rect_y_q   <= rect_y_d;
            mov_left_q <= mov_left_d;
            mov_up_q   <= mov_up_d;
            bounce_q   <= bounce_d;
            hit_q      <= hit_d;
            inside1_q  <= inside1_d;
            de1_q      <= de;
            out_de_q   <= de1_q;
            colour_q   <= colour_d;
        end
    end

`ifdef BOUNCE_DRAW_PALETTE_EN
    localparam logic [CHW-1:0] RC_R = RECT_COLOUR[COLW-1 -: CHW];
    localparam logic [CHW-1:0] RC_G = RECT_COLOUR[2*CHW-1 -: CHW];
    localparam logic [CHW-1:0] RC_B = RECT_COLOUR[CHW-1:0];

    logic [1:0] pal_idx_q, pal_idx_d;

    always_comb begin
        pal_idx_d = pal_idx_q + {1'b0, hit_q};
        case (pal_idx_q)
            2'd0:    rect_col = RECT_COLOUR;
            2'd1:    rect_col = {RC_G, RC_B, RC_R};
            2'd2:    rect_col = {RC_B, RC_R, RC_G};
            default: rect_col = ~RECT_COLOUR;
        endcase
    end

    always_ff @(posedge pix_clk) begin
        if (rst_pix) pal_idx_q <= '0;
        else         pal_idx_q <= pal_idx_d;
    end
`else
    assign rect_col = RECT_COLOUR;
`endif

    assign out_de = out_de_q;
    assign out_r  = colour_q[COLW-1 -: CHW];
    assign out_g  = colour_q[2*CHW-1 -: CHW];
    assign out_b  = colour_q[CHW-1:0];
    assign rect_x = rect_x_q;
    assign rect_y = rect_y_q;
    assign hit    = hit_q;

endmodule

// File: tb/tb_bounce_draw.sv
// Self-checking bench for bounce_draw: two instances (default start and near-corner start)
// driven by random frame/pause/pixel stimulus and compared against a plain-arithmetic model.
module tb_bounce_draw;

    logic       pix_clk = 1'b0;
    logic       rst_pix, de, frame, pause;
    logic [9:0] sx, sy;

    logic       out_de [2];
    logic [3:0] out_r [2], out_g [2], out_b [2];
    logic [9:0] rect_x [2], rect_y [2];
    logic       hit [2];

    int checks = 0;
    int errors = 0;

    // Model state: position, direction (1 = left/up), palette index per instance.
    int mx [2], my [2], midx [2];
    bit mlx [2], mly [2];
    int start_x [2] = '{300, 604};
    int start_y [2] = '{200, 454};

    typedef struct { bit e0; logic [11:0] c0; bit e1; logic [11:0] c1; } pix_exp_t;
    pix_exp_t pq [$];

    always #5 pix_clk = ~pix_clk;

    bounce_draw #(.START_X(300), .START_Y(200)) u_dut0 (
        .pix_clk(pix_clk), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
        .frame(frame), .pause(pause), .out_de(out_de[0]), .out_r(out_r[0]),
        .out_g(out_g[0]), .out_b(out_b[0]), .rect_x(rect_x[0]), .rect_y(rect_y[0]),
        .hit(hit[0]));

    bounce_draw #(.START_X(604), .START_Y(454)) u_dut1 (
        .pix_clk(pix_clk), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
        .frame(frame), .pause(pause), .out_de(out_de[1]), .out_r(out_r[1]),
        .out_g(out_g[1]), .out_b(out_b[1]), .rect_x(rect_x[1]), .rect_y(rect_y[1]),
        .hit(hit[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mx[d] = start_x[d]; my[d] = start_y[d];
            mlx[d] = 1'b0; mly[d] = 1'b0; midx[d] = 0;
        end
    endtask

    function automatic logic [11:0] rect_colour(input int idx);
        logic [11:0] pal [4];
        pal = '{12'h63F, 12'h3F6, 12'hF63, 12'h9C0};
`ifdef BOUNCE_DRAW_PALETTE_EN
        return pal[idx];
`else
        return pal[0];
`endif
    endfunction

    function automatic logic [11:0] exp_colour(input int d, input int x, input int y, input bit e);
        if (!e) return 12'h000;
        if (x >= mx[d] && x < mx[d] + 32 && y >= my[d] && y < my[d] + 24)
            return rect_colour(midx[d]);
        return 12'h142;
    endfunction

    // One axis step: bounce clamps to the edge and reverses.
    task automatic step_axis(input int pos, input bit neg, input int spd, input int lim,
                             output int npos, output bit nneg, output bit b);
        npos = pos; nneg = neg; b = 1'b0;
        if (!neg) begin
            if (pos >= lim - spd) begin npos = lim; nneg = 1'b1; b = 1'b1; end
            else npos = pos + spd;
        end else begin
            if (pos <= spd) begin npos = 0; nneg = 1'b0; b = 1'b1; end
            else npos = pos - spd;
        end
    endtask

    // Drive one pixel, then compare the outputs belonging to the pixel of the previous call.
    task automatic pix_step(input int x, input int y, input bit e);
        pix_exp_t pe, old;
        sx = 10'(x); sy = 10'(y); de = e;
        pe.e0 = e; pe.c0 = exp_colour(0, x, y, e);
        pe.e1 = e; pe.c1 = exp_colour(1, x, y, e);
        pq.push_back(pe);
        tick();
        if (pq.size() >= 2) begin
            old = pq.pop_front();
            check("pix_de0", 32'(out_de[0]), 32'(old.e0));
            check("pix_col0", {20'h0, out_r[0], out_g[0], out_b[0]}, {20'h0, old.c0});
            check("pix_de1", 32'(out_de[1]), 32'(old.e1));
            check("pix_col1", {20'h0, out_r[1], out_g[1], out_b[1]}, {20'h0, old.c1});
        end
    endtask

    task automatic pix_burst(input int n);
        int d, lo, x, y;
        pq.delete();
        d = int'($urandom_range(0, 1));
        pix_step(mx[d] + 16, my[d] + 12, 1'b1);
        for (int i = 0; i < n; i++) begin
            d  = int'($urandom_range(0, 1));
            lo = (mx[d] > 3) ? mx[d] - 3 : 0;
            x  = int'($urandom_range(lo, lo + 38));
            lo = (my[d] > 3) ? my[d] - 3 : 0;
            y  = int'($urandom_range(lo, lo + 30));
            if (x > 639) x = 639;
            if (y > 479) y = 479;
            pix_step(x, y, $urandom_range(0, 4) != 0);
        end
        pix_step(0, 0, 1'b0);
    endtask

    task automatic do_frame(input bit p, input bit dbl);
        int nx [2], ny [2];
        bit nlx [2], nly [2], bx [2], by [2];
        for (int d = 0; d < 2; d++) begin
            nx[d] = mx[d]; ny[d] = my[d]; nlx[d] = mlx[d]; nly[d] = mly[d];
            bx[d] = 1'b0; by[d] = 1'b0;
            if (!p) begin
                step_axis(mx[d], mlx[d], 2, 608, nx[d], nlx[d], bx[d]);
                step_axis(my[d], mly[d], 1, 456, ny[d], nly[d], by[d]);
            end
        end
        frame = 1'b1; pause = p;
        tick();
        frame = dbl; pause = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("x_before%0d", d), 32'(rect_x[d]), 32'(mx[d]));
            check($sformatf("hit_early%0d", d), 32'(hit[d]), 32'd0);
        end
        tick();
        frame = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("x_step%0d", d), 32'(rect_x[d]), 32'(nx[d]));
            check($sformatf("y_hold%0d", d), 32'(rect_y[d]), 32'(my[d]));
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("y_step%0d", d), 32'(rect_y[d]), 32'(ny[d]));
            check($sformatf("hit%0d", d), 32'(hit[d]), 32'(bx[d] | by[d]));
            mx[d] = nx[d]; my[d] = ny[d]; mlx[d] = nlx[d]; mly[d] = nly[d];
            if (bx[d] | by[d]) midx[d] = (midx[d] + 1) % 4;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("hit_once%0d", d), 32'(hit[d]), 32'd0);
            check($sformatf("x_settled%0d", d), 32'(rect_x[d]), 32'(mx[d]));
            check($sformatf("y_settled%0d", d), 32'(rect_y[d]), 32'(my[d]));
        end
    endtask

    initial begin
        bit p, dbl;
        int hits_before;
        rst_pix = 1'b1; de = 1'b1; frame = 1'b0; pause = 1'b0; sx = 10'd300; sy = 10'd200;
        model_reset();
        tick(); tick();
        rst_pix = 1'b0;

        // Directed pixels around the reset-position rectangle.
        pq.delete();
        pix_step(300, 200, 1'b1);
        pix_step(299, 200, 1'b1);
        pix_step(331, 223, 1'b1);
        pix_step(332, 200, 1'b1);
        pix_step(300, 224, 1'b1);
        pix_step(300, 200, 1'b0);
        pix_step(300, 200, 1'b1);
        pix_step(300, 200, 1'b1);

        // One-cycle reset with a full pipeline: everything returns to its reset value.
        rst_pix = 1'b1;
        tick();
        rst_pix = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_x%0d", d), 32'(rect_x[d]), 32'(start_x[d]));
            check($sformatf("rst_y%0d", d), 32'(rect_y[d]), 32'(start_y[d]));
            check($sformatf("rst_de%0d", d), 32'(out_de[d]), 32'd0);
            check($sformatf("rst_col%0d", d), {20'h0, out_r[d], out_g[d], out_b[d]}, 32'h0);
            check($sformatf("rst_hit%0d", d), 32'(hit[d]), 32'd0);
        end

        // Normal move, then right/corner bounce on instance 1, then reversal.
        do_frame(1'b0, 1'b0);
        do_frame(1'b0, 1'b0);
        do_frame(1'b0, 1'b0);
        pix_burst(6);
        do_frame(1'b1, 1'b0);
        do_frame(1'b0, 1'b1);
        pix_burst(6);

        // Reset in the middle of an update abandons it.
        frame = 1'b1;
        tick();
        frame = 1'b0; rst_pix = 1'b1;
        tick();
        rst_pix = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("abort_x%0d", d), 32'(rect_x[d]), 32'(start_x[d]));
                check($sformatf("abort_y%0d", d), 32'(rect_y[d]), 32'(start_y[d]));
                check($sformatf("abort_hit%0d", d), 32'(hit[d]), 32'd0);
            end
        end

        // Long random run: several bounces on both axes of both instances.
        for (int f = 0; f < 1100; f++) begin
            p   = ($urandom_range(0, 3) == 0);
            dbl = !p && ($urandom_range(0, 7) == 0);
            hits_before = midx[0] + midx[1] * 4;
            do_frame(p, dbl);
            if (hits_before != midx[0] + midx[1] * 4 || (f % 16) == 0) pix_burst(5);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bounce_draw.md
Name: bounce_draw

Overview:
- Parametrised successor to the static-rectangle renderer in the pong top level.
- Draws one axis-aligned rectangle over a flat background and animates it: the rectangle moves once per frame and bounces off the active-area edges.
- Sits between display_signal (sx, sy, de) and the DVI/SDL output stage.
- Colour depth, resolution, sprite size, speed and start position are all parameters.

Parameters:
- CORDW, 10, coordinate width [bits]
- CHW, 4, colour channel width [bits]
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- RECT_W, 32, rectangle width [pixels]
- RECT_H, 24, rectangle height [pixels]
- SPEED_X, 2, horizontal step per frame [pixels]; 1..RECT_W
- SPEED_Y, 1, vertical step per frame [pixels]; 1..RECT_H
- START_X, 300, reset x position (left edge); 0..H_RES-RECT_W
- START_Y, 200, reset y position (top edge); 0..V_RES-RECT_H
- RECT_COLOUR, 12'h63F, packed {r,g,b} rectangle colour, 3*CHW bits
- BG_COLOUR, 12'h142, packed {r,g,b} background colour, 3*CHW bits

Ports:
- pix_clk  in  1  pixel clock; the only clock
- rst_pix  in  1  reset, synchronous, active-high
- sx  in  CORDW  active-area x coordinate, 0..H_RES-1 while de=1
- sy  in  CORDW  active-area y coordinate, 0..V_RES-1 while de=1
- de  in  1  data enable, aligned with sx/sy
- frame  in  1  single-cycle pulse, once per frame, during vertical blanking
- pause  in  1  when high at a frame pulse, that frame's movement is suppressed
- out_de  out  1  de delayed by 2 cycles
- out_r, out_g, out_b  out  CHW each  pixel colour, aligned with out_de
- rect_x  out  CORDW  current rectangle left edge
- rect_y  out  CORDW  current rectangle top edge
- hit  out  1  one-cycle pulse when any edge bounce occurs

Behaviour:
- Reset (rst_pix=1 at a pix_clk edge) sets:
  - rect_x=START_X, rect_y=START_Y
  - dir_x=right, dir_y=down
  - state=IDLE
  - out_de=0, out_r/g/b=0, hit=0
  - both pipeline stages cleared
- A reset mid-update abandons the update.
- FSM states IDLE, UPD_X, UPD_Y:
  - IDLE -> UPD_X on frame=1 && pause=0; otherwise stays in IDLE.
  - UPD_X: x step; -> UPD_Y.
  - UPD_Y: y step; -> IDLE.
  - A frame pulse outside IDLE is ignored. A pulse with pause=1 is ignored.
- X step, moving right:
  - If rect_x >= H_RES-RECT_W-SPEED_X: rect_x <= H_RES-RECT_W, dir_x <= left, bounce.
  - Else rect_x <= rect_x+SPEED_X.
- X step, moving left:
  - If rect_x <= SPEED_X: rect_x <= 0, dir_x <= right, bounce.
  - Else rect_x <= rect_x-SPEED_X.
- Y step: same rules using V_RES, RECT_H and SPEED_Y.
- Arithmetic: compares use CORDW+1 bits so nothing wraps; rect_x/rect_y never leave the legal range.
- hit is asserted for exactly one cycle, in the cycle after UPD_Y, if either axis bounced in that update. A corner bounce gives a single hit pulse.
- Pixel pipeline, fixed 2-cycle latency, independent of the FSM:
  - Stage 1 registers: inside = sx>=rect_x && sx<rect_x+RECT_W && sy>=rect_y && sy<rect_y+RECT_H; also de.
  - Stage 2 registers: colour = de1 ? (inside1 ? RECT_COLOUR : BG_COLOUR) : 0; out_de = de1.
- Position registers change only while in UPD_X/UPD_Y. Because frame arrives in blanking, no tearing occurs within a visible frame.

Optional Feature:
- Macro: BOUNCE_DRAW_PALETTE_EN
- Defined:
  - Adds a 2-bit palette index, reset to 0, incremented (mod 4) on every hit pulse.
  - Rectangle colour = palette[idx]: idx 0 = RECT_COLOUR; idx 1/2/3 = RECT_COLOUR with the channels rotated {g,b,r}, {b,r,g}, and bitwise-inverted.
  - The new colour takes effect from the cycle after hit.
- Undefined: rectangle colour is always RECT_COLOUR; no palette register exists.

Test Plan:
- Reset latency: rst_pix=1 for 1 cycle -> rect_x=300, rect_y=200, out_de=0, out_r/g/b=0, hit=0. Then drive sx=300, sy=200, de=1 -> two cycles later out_de=1, {r,g,b}=12'h63F. Drive sx=299 -> 12'h142. Drive de=0 -> 12'h000.
- Normal move: START_X=300, START_Y=200, one frame pulse -> after 2 cycles rect_x=302, rect_y=201, no hit.
- Right bounce: START_X=604. Frame pulses -> rect_x 606, then 608 with hit pulse and dir_x=left, then 606.
- Corner bounce: START_X=1, START_Y=0 with dir forced left/up (via prior bounces or SPEED_X=2, START_X=2 after reversal) -> rect_x=0, rect_y=0, exactly one hit pulse, both directions reversed.
- Pause/overlap: frame=1 with pause=1 -> no position change. A second frame pulse in the cycle after the first (state UPD_X) -> ignored, rect_x advanced only once.
- Palette (with BOUNCE_DRAW_PALETTE_EN): 4 consecutive bounces -> rectangle colour sequence 63F, 3F6, F63, 9C0, then back to 63F. Without the macro -> colour stays 63F.
